// File: rtl/enc_sample_sched.sv
// Periodic snapshot of all encoder counts, then one signed delta per channel over a valid/ready stream.
// Optional macro ENC_SCHED_SEQ_EN adds an 8-bit per-set sequence number output (delta_seq).
module enc_sample_sched #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16,
  parameter int PERIOD = 50000,
  parameter int PER_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [NUM_CH*CNT_W-1:0] enc_count,
  output logic                    delta_valid,
  input  logic                    delta_ready,
  output logic [2:0]              delta_ch,
  output logic [CNT_W-1:0]        delta,
  output logic                    busy,
  output logic                    overrun,
  input  logic                    overrun_clr
`ifdef ENC_SCHED_SEQ_EN
  ,
  output logic [7:0]              delta_seq
`endif
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [PER_W-1:0] TB_LAST = PER_W'(PERIOD - 1);
  localparam logic [CH_W-1:0]  CH_LAST = CH_W'(NUM_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PRESENT} state_t;

  state_t             state_q;
  logic [PER_W-1:0]   tb_q, tb_d;
  logic               tick;
  logic               primed_q;
  logic [CH_W-1:0]    ch_q;
  logic [CNT_W-1:0]   snap_q [NUM_CH];
  logic [CNT_W-1:0]   prev_q [NUM_CH];
  logic [CNT_W-1:0]   diff;
  logic               delta_valid_q;
  logic [2:0]         delta_ch_q;
  logic [CNT_W-1:0]   delta_q;
  logic               overrun_q, overrun_d;
  logic               accept;
`ifdef ENC_SCHED_SEQ_EN
  logic [7:0]         seq_q;
`endif

  // Stream handshake: a delta transfers on any clock edge where delta_valid and
  // delta_ready are both high; delta/delta_ch are held stable while valid is high.
  assign accept = delta_valid_q && delta_ready;
  assign tick   = enable && (tb_q == TB_LAST);

  always_comb begin
    tb_d = tb_q + PER_W'(1);
    if (!enable || tick) tb_d = '0;
  end

  // A tick that finds the scheduler busy is dropped; set beats clear.
  always_comb begin
    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (tick && (state_q != S_IDLE)) overrun_d = 1'b1;
  end

  // Single shared subtractor; modulo arithmetic makes counter wrap-through correct.
  assign diff = snap_q[ch_q] - prev_q[ch_q];

  always_ff @(posedge clk) begin
    if (!reset) begin
      tb_q      <= '0;
      overrun_q <= 1'b0;
    end else begin
      tb_q      <= tb_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      ch_q          <= '0;
      primed_q      <= 1'b0;
      delta_valid_q <= 1'b0;
      delta_ch_q    <= '0;
      delta_q       <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        snap_q[k] <= '0;
        prev_q[k] <= '0;
      end
`ifdef ENC_SCHED_SEQ_EN
      seq_q         <= '0;
`endif
    end else begin
      // Disabling forgets the baseline so stale counts never produce a delta.
      if (!enable) primed_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (tick) begin
            if (!primed_q) begin
              for (int k = 0; k < NUM_CH; k++) prev_q[k] <= enc_count[k*CNT_W +: CNT_W];
              primed_q <= 1'b1;
            end else begin
              for (int k = 0; k < NUM_CH; k++) snap_q[k] <= enc_count[k*CNT_W +: CNT_W];
              ch_q    <= '0;
              state_q <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          delta_q       <= diff;
          prev_q[ch_q]  <= snap_q[ch_q];
          delta_ch_q    <= 3'(ch_q);
          delta_valid_q <= 1'b1;
          state_q       <= S_PRESENT;
        end
        S_PRESENT: begin
          if (accept) begin
            delta_valid_q <= 1'b0;
            if (ch_q == CH_LAST) begin
              state_q <= S_IDLE;
`ifdef ENC_SCHED_SEQ_EN
              seq_q   <= seq_q + 8'd1;
`endif
            end else begin
              ch_q    <= ch_q + CH_W'(1);
              state_q <= S_LOAD;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign delta_valid = delta_valid_q;
  assign delta_ch    = delta_ch_q;
  assign delta       = delta_q;
  assign busy        = (state_q != S_IDLE);
  assign overrun     = overrun_q;
`ifdef ENC_SCHED_SEQ_EN
  assign delta_seq   = seq_q;
`endif

endmodule

// File: tb/tb_enc_sample_sched.sv
// Directed bench for enc_sample_sched: priming, deltas with wrap, backpressure, overrun, reset and enable drop.
// Checks delta_seq as well when ENC_SCHED_SEQ_EN is defined.
module tb_enc_sample_sched;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 16;
  localparam int PERIOD = 16;
  localparam int PER_W  = 16;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    enable = 1'b0;
  logic [NUM_CH*CNT_W-1:0] enc_count = '0;
  logic                    delta_ready = 1'b1;
  logic                    overrun_clr = 1'b0;
  logic                    delta_valid;
  logic [2:0]              delta_ch;
  logic [CNT_W-1:0]        delta;
  logic                    busy;
  logic                    overrun;
`ifdef ENC_SCHED_SEQ_EN
  logic [7:0]              delta_seq;
`endif

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] exp_seq = '0;
  int         tbm = 0;
  logic       tick_m;

  enc_sample_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PERIOD(PERIOD), .PER_W(PER_W)) dut (
    .clk(clk), .reset(reset), .enable(enable), .enc_count(enc_count),
    .delta_valid(delta_valid), .delta_ready(delta_ready), .delta_ch(delta_ch),
    .delta(delta), .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
`ifdef ENC_SCHED_SEQ_EN
    , .delta_seq(delta_seq)
`endif
  );

  // clock / reference timebase
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset || !enable) tbm <= 0;
    else if (tbm == PERIOD - 1) tbm <= 0;
    else tbm <= tbm + 1;
  end
  assign tick_m = enable && (tbm == PERIOD - 1);

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic to_tick();
    int n = 0;
    while (!tick_m && n < 3 * PERIOD) begin
      step();
      n++;
    end
    if (!tick_m) begin
      n_err++;
      $display("FAIL tick_wait: no tick after %0d cycles, required one", n);
    end
  endtask

  task automatic start_set(input string tag, input logic [63:0] cnt);
    to_tick();
    enc_count = cnt;
    step();
    n_vec++;
    if (busy !== 1'b1 || delta_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_lat1: busy=%b delta_valid=%b, required 1/0", tag, busy, delta_valid);
    end
    step();
    n_vec++;
    if (delta_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s_lat2: delta_valid=%b, required 1", tag, delta_valid);
    end
`ifdef ENC_SCHED_SEQ_EN
    n_vec++;
    if (delta_seq !== exp_seq) begin
      n_err++;
      $display("FAIL %s_seq: delta_seq=%0d, required %0d", tag, delta_seq, exp_seq);
    end
`endif
  endtask

  task automatic take_ch(input string tag, input int k, input logic [15:0] e);
    int n = 0;
    while (delta_valid !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    n_vec++;
    if (delta_valid !== 1'b1) begin
      n_err++;
      $display("FAIL %s_valid%0d: delta_valid=%b, required 1", tag, k, delta_valid);
    end
    n_vec++;
    if (delta_ch !== 3'(k)) begin
      n_err++;
      $display("FAIL %s_ch%0d: delta_ch=%0d, required %0d", tag, k, delta_ch, k);
    end
    n_vec++;
    if (delta !== e) begin
      n_err++;
      $display("FAIL %s_delta%0d: delta=%h, required %h", tag, k, delta, e);
    end
    step();
  endtask

  task automatic take_all(input string tag, input logic [63:0] e);
    for (int k = 0; k < NUM_CH; k++) take_ch(tag, k, e[k*16 +: 16]);
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL %s_done: busy=%b, required 0", tag, busy);
    end
    exp_seq++;
  endtask

  task automatic quiet_window(input string tag, input int cycles);
    logic seen = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      if (delta_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
      step();
    end
    n_vec++;
    if (seen !== 1'b0) begin
      n_err++;
      $display("FAIL %s_quiet: output activity seen=%b, required 0", tag, seen);
    end
  endtask

  task automatic prime(input string tag, input logic [63:0] cnt);
    to_tick();
    enc_count = cnt;
    step();
    quiet_window(tag, 8);
  endtask

  // scenarios
  task automatic test_reset();
    reset = 1'b0;
    enable = 1'b0;
    repeat (3) step();
    n_vec++;
    if (delta_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL reset_flags: valid=%b busy=%b overrun=%b, required 0/0/0", delta_valid, busy, overrun);
    end
    n_vec++;
    if (delta !== 16'h0000 || delta_ch !== 3'd0) begin
      n_err++;
      $display("FAIL reset_data: delta=%h delta_ch=%0d, required 0000/0", delta, delta_ch);
    end
`ifdef ENC_SCHED_SEQ_EN
    n_vec++;
    if (delta_seq !== 8'd0) begin
      n_err++;
      $display("FAIL reset_seq: delta_seq=%0d, required 0", delta_seq);
    end
`endif
    reset = 1'b1;
    step();
  endtask

  task automatic test_basic();
    enable = 1'b1;
    prime("prime0", 64'h0);
    start_set("basic", 64'h7FFF_0000_FFFD_000A);
    take_all("basic", 64'h7FFF_0000_FFFD_000A);
  endtask

  task automatic test_wrap();
    start_set("s3", 64'h8000_0000_FFFE_000A);
    take_all("s3", 64'h0001_0000_0001_0000);
    start_set("wrap_up", 64'h8000_0064_0003_0000);
    take_all("wrap_up", 64'h0000_0064_0005_FFF6);
    start_set("wrap_dn", 64'h8005_0064_FFFE_0000);
    take_all("wrap_dn", 64'h0005_0000_FFFB_0000);
  endtask

  task automatic test_backpressure();
    int n = 0;
    start_set("bp", 64'h8005_012C_FFFE_0005);
    take_ch("bp", 0, 16'h0005);
    take_ch("bp", 1, 16'h0000);
    while (delta_valid !== 1'b1 && n < 8) begin
      step();
      n++;
    end
    delta_ready = 1'b0;
    enc_count = 64'h4444_3333_2222_1111;
    for (int i = 0; i < 12; i++) begin
      n_vec++;
      if (delta_valid !== 1'b1 || delta_ch !== 3'd2 || delta !== 16'h00C8) begin
        n_err++;
        $display("FAIL bp_hold%0d: valid=%b ch=%0d delta=%h, required 1/2/00c8", i, delta_valid, delta_ch, delta);
      end
      step();
    end
    delta_ready = 1'b1;
    take_ch("bp", 2, 16'h00C8);
    take_ch("bp", 3, 16'h0000);
    exp_seq++;
    n_vec++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL bp_overrun: overrun=%b, required 1", overrun);
    end
    start_set("after_ovr", 64'h8000_012C_FFFF_0007);
    take_all("after_ovr", 64'hFFFB_0000_0001_0002);
  endtask

  task automatic test_overrun_clr();
    if (tick_m) step();
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    n_vec++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL clr_plain: overrun=%b, required 0", overrun);
    end
    start_set("clr_coinc", 64'h8000_012C_FFFF_0007);
    delta_ready = 1'b0;
    to_tick();
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    n_vec++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL clr_coinc: overrun=%b, required 1", overrun);
    end
    delta_ready = 1'b1;
    take_all("clr_coinc", 64'h0);
    if (tick_m) step();
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    start_set("rmid", 64'h8000_012C_0000_0009);
    take_ch("rmid", 0, 16'h0002);
    take_ch("rmid", 1, 16'h0001);
    delta_ready = 1'b0;
    step();
    delta_ready = 1'b0;
    to_tick();
    step();
    n_vec++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL rmid_ovr: overrun=%b, required 1", overrun);
    end
    reset = 1'b0;
    step();
    n_vec++;
    if (delta_valid !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      n_err++;
      $display("FAIL rmid_flags: valid=%b busy=%b overrun=%b, required 0/0/0", delta_valid, busy, overrun);
    end
`ifdef ENC_SCHED_SEQ_EN
    n_vec++;
    if (delta_seq !== 8'd0) begin
      n_err++;
      $display("FAIL rmid_seq: delta_seq=%0d, required 0", delta_seq);
    end
`endif
    reset = 1'b1;
    delta_ready = 1'b1;
    exp_seq = '0;
    prime("rmid_prime", 64'h4000_3000_2000_1000);
    start_set("post_rst", 64'h4010_3000_1FFF_1001);
    take_all("post_rst", 64'h0010_0000_FFFF_0001);
  endtask

  task automatic test_enable_drop();
    start_set("endrop", 64'h4010_3000_2004_1005);
    take_ch("endrop", 0, 16'h0004);
    take_ch("endrop", 1, 16'h0005);
    enable = 1'b0;
    take_ch("endrop", 2, 16'h0000);
    take_ch("endrop", 3, 16'h0000);
    exp_seq++;
    n_vec++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL endrop_busy: busy=%b, required 0", busy);
    end
    quiet_window("disabled", 2 * PERIOD);
    enc_count = 64'h8000_7000_6000_5000;
    enable = 1'b1;
    prime("reprime", 64'h8000_7000_6000_5000);
    start_set("reen", 64'h8001_7000_5FF0_5003);
    take_all("reen", 64'h0001_0000_FFF0_0003);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_overrun_clr();
    test_reset_mid();
    test_enable_drop();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
